pcie_ext_cap_walker: RTL and testbench

Initiator-side walker for the PCIe Extended Capability list in configuration space. On start it reads dword headers from offset 100h and decodes each one: ID [15:0], version [19:16], next pointer [31:20]. It follows the next pointers until it finds a target capability ID, reaches the end of the list, or detects a fault. It sits between config-space access logic and any block that needs a capability's offset, such as AER or DPC setup.

---
 rtl/pcie_ext_cap_walker.sv | 168 ++++++++++++++++
 tb/tb_pcie_ext_cap_walker.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_ext_cap_walker.sv
// PCIe Extended Capability list walker.
// Starting at config offset 100h it reads each extended capability header,
// follows the next pointers and reports where the requested capability ID
// lives. A walk ends on a match, at the end of the list, on a malformed
// header or pointer, when the hop limit is reached, or when a read times out.
module pcie_ext_cap_walker #(
    parameter int MAX_HOPS   = 64,
    parameter int RD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] target_id,
    output logic        rd_req,
    output logic [11:0] rd_addr,
    input  logic        rd_valid,
    input  logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [11:0] cap_offset,
    output logic [3:0]  cap_version,
    output logic [7:0]  hops,
    output logic [1:0]  error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_EVAL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b01;
    localparam logic [1:0] ERR_MALFORMED = 2'b10;
    localparam logic [1:0] ERR_HOPS      = 2'b11;

    localparam logic [11:0] BASE_ADDR  = 12'h100;
    localparam logic [7:0]  HOP_LIMIT  = 8'(MAX_HOPS);
    // The counter holds the number of REQ cycles already elapsed, so the
    // final permitted cycle is the one where it equals RD_TIMEOUT-1.
    localparam logic [9:0]  TMO_LAST   = 10'(RD_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [11:0] cur_addr_q, cur_addr_d;
    logic [7:0]  hops_q, hops_d;
    logic [9:0]  tmo_q, tmo_d;
    logic [31:0] hdr_q, hdr_d;
    logic [15:0] target_q, target_d;
    logic        found_q, found_d;
    logic [11:0] cap_offset_q, cap_offset_d;
    logic [3:0]  cap_version_q, cap_version_d;
    logic [1:0]  error_q, error_d;

    logic [11:0] next_ptr;

    assign next_ptr = hdr_q[31:20];

    // Next-state and result computation for the walk FSM.
    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        hops_d        = hops_q;
        tmo_d         = tmo_q;
        hdr_d         = hdr_q;
        target_d      = target_q;
        found_d       = found_q;
        cap_offset_d  = cap_offset_q;
        cap_version_d = cap_version_q;
        error_d       = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    target_d      = target_id;
                    cur_addr_d    = BASE_ADDR;
                    hops_d        = '0;
                    tmo_d         = '0;
                    found_d       = 1'b0;
                    cap_offset_d  = '0;
                    cap_version_d = '0;
                    error_d       = ERR_NONE;
                    state_d       = S_REQ;
                end
            end
            S_REQ: begin
                // A response on the last permitted cycle still counts.
                if (rd_valid) begin
                    hdr_d   = rd_data;
                    hops_d  = hops_q + 8'd1;
                    tmo_d   = '0;
                    state_d = S_EVAL;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    error_d = ERR_TIMEOUT;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 10'd1;
                end
            end
            S_EVAL: begin
                state_d = S_DONE;
                if (hdr_q == 32'hFFFF_FFFF) begin
                    // All-ones means nothing answered at this offset.
                    error_d = ERR_MALFORMED;
                end else if (hdr_q == 32'h0 && cur_addr_q == BASE_ADDR) begin
                    // Empty extended capability list: not found, no error.
                    found_d = 1'b0;
                end else if (hdr_q[15:0] == target_q) begin
                    found_d       = 1'b1;
                    cap_offset_d  = cur_addr_q;
                    cap_version_d = hdr_q[19:16];
                end else if (next_ptr == 12'h0) begin
                    // Natural end of list without a match.
                    found_d = 1'b0;
                end else if (next_ptr < BASE_ADDR || next_ptr[1:0] != 2'b00) begin
                    error_d = ERR_MALFORMED;
                end else if (hops_q == HOP_LIMIT) begin
                    // Guards against looped lists.
                    error_d = ERR_HOPS;
                end else begin
                    cur_addr_d = next_ptr;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any walk silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cur_addr_q    <= '0;
            hops_q        <= '0;
            tmo_q         <= '0;
            hdr_q         <= '0;
            target_q      <= '0;
            found_q       <= 1'b0;
            cap_offset_q  <= '0;
            cap_version_q <= '0;
            error_q       <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            hops_q        <= hops_d;
            tmo_q         <= tmo_d;
            hdr_q         <= hdr_d;
            target_q      <= target_d;
            found_q       <= found_d;
            cap_offset_q  <= cap_offset_d;
            cap_version_q <= cap_version_d;
            error_q       <= error_d;
        end
    end

    assign rd_req      = (state_q == S_REQ);
    assign rd_addr     = (state_q == S_REQ) ? cur_addr_q : 12'h0;
    assign busy        = (state_q == S_REQ) || (state_q == S_EVAL);
    assign done        = (state_q == S_DONE);
    assign found       = found_q;
    assign cap_offset  = cap_offset_q;
    assign cap_version = cap_version_q;
    assign hops        = hops_q;
    assign error       = error_q;

endmodule

// File: tb/tb_pcie_ext_cap_walker.sv
// Scoreboard bench for pcie_ext_cap_walker: a config-space responder with
// programmable wait states, a list-walking reference model, and a monitor
// that checks every accepted read address and every walk result.
module tb_pcie_ext_cap_walker;

    localparam int MAX_HOPS   = 64;
    localparam int RD_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] target_id;
    logic        rd_req;
    logic [11:0] rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        found;
    logic [11:0] cap_offset;
    logic [3:0]  cap_version;
    logic [7:0]  hops;
    logic [1:0]  error;

    pcie_ext_cap_walker #(.MAX_HOPS(MAX_HOPS), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .target_id(target_id),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .found(found), .cap_offset(cap_offset),
        .cap_version(cap_version), .hops(hops), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        found;
        logic [11:0] off;
        logic [3:0]  ver;
        logic [7:0]  hops;
        logic [1:0]  err;
        int          reqcyc;
        int          lat;
        int          scyc;
    } exp_t;

    exp_t        expq[$];
    logic [11:0] addrq[$];
    logic [31:0] mem [0:1023];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int wmode  = 0;   // wait states per read, -1 = never respond
    int wcnt   = 0;
    logic spur = 1'b0; // rd_valid driven while no request is pending
    int reqcnt = 0;
    logic done_prev = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event (t=%0t)", nm, $time);
    endtask

    always @(posedge clk) cyc++;

    // Config-space responder.
    always @(posedge clk) begin
        #1;
        if (rst || !rd_req) begin
            wcnt     = 0;
            rd_valid = spur;
            rd_data  = 32'hDEAD_BEEF;
        end else begin
            if (wmode >= 0 && wcnt == wmode) begin
                rd_valid = 1'b1;
                rd_data  = mem[rd_addr[11:2]];
            end else begin
                rd_valid = 1'b0;
                rd_data  = $urandom;
            end
            wcnt++;
        end
    end

    // Monitor: compares accepted reads and walk results against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            reqcnt    = 0;
            done_prev = 1'b0;
        end else begin
            if (rd_req) reqcnt++;
            if (rd_req && rd_valid) begin
                if (addrq.size() == 0) fail_event("rd_addr_extra_read");
                else check("rd_addr", 32'(rd_addr), 32'(addrq.pop_front()));
            end
            if (done) begin
                if (done_prev) fail_event("done_wider_than_one_cycle");
                else if (expq.size() == 0) fail_event("done_unexpected");
                else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("found",       32'(found),       32'(e.found));
                    check("cap_offset",  32'(cap_offset),  32'(e.off));
                    check("cap_version", 32'(cap_version), 32'(e.ver));
                    check("hops",        32'(hops),        32'(e.hops));
                    check("error",       32'(error),       32'(e.err));
                    check("rd_req_cycles", 32'(reqcnt),    32'(e.reqcyc));
                    check("done_latency", 32'(cyc - e.scyc), 32'(e.lat));
                    check("busy_in_done", 32'(busy),       32'd0);
                end
                reqcnt = 0;
            end
            done_prev = done;
        end
    end

    function automatic logic [31:0] hdr(input logic [15:0] id, input logic [3:0] ver,
                                        input logic [11:0] nxt);
        return {nxt, ver, id};
    endfunction

    // Reference model: walk the memory image following the list rules.
    task automatic model(input logic [15:0] tgt, input int w, output exp_t e);
        logic [11:0] a;
        logic [31:0] h;
        logic [11:0] nxt;
        int          n;
        e = '{found: 1'b0, off: 12'h0, ver: 4'h0, hops: 8'h0, err: 2'b00,
              reqcyc: 0, lat: 0, scyc: 0};
        if (w < 0) begin
            e.err    = 2'b01;
            e.reqcyc = RD_TIMEOUT;
            e.lat    = RD_TIMEOUT + 1;
            return;
        end
        a = 12'h100;
        n = 0;
        while (1) begin
            h = mem[a[11:2]];
            n++;
            addrq.push_back(a);
            nxt = h[31:20];
            if (h == 32'hFFFF_FFFF) begin e.err = 2'b10; break; end
            if (h == 32'h0 && a == 12'h100) break;
            if (h[15:0] == tgt) begin e.found = 1'b1; e.off = a; e.ver = h[19:16]; break; end
            if (nxt == 12'h0) break;
            if (nxt < 12'h100 || nxt[1:0] != 2'b00) begin e.err = 2'b10; break; end
            if (n == MAX_HOPS) begin e.err = 2'b11; break; end
            a = nxt;
        end
        e.hops   = 8'(n);
        e.reqcyc = n * (w + 1);
        e.lat    = n * (w + 2) + 1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            if (done) return;
            @(posedge clk); #1;
        end
        fail_event("done_never_arrived");
    endtask

    task automatic pulse_start(input logic [15:0] tgt);
        target_id = tgt;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // One walk: push expectation, issue start, optionally poke start while
    // busy or in the DONE cycle, and wait for completion. Call at posedge+1.
    task automatic walk(input logic [15:0] tgt, input int w, input bit busy_poke,
                        input bit done_poke);
        exp_t e;
        wmode = w;
        model(tgt, w, e);
        e.scyc = cyc;
        expq.push_back(e);
        pulse_start(tgt);
        if (busy_poke) begin
            @(posedge clk); #1;
            check("busy_before_poke", 32'(busy), 32'd1);
            pulse_start(~tgt);
        end
        wait_done();
        if (done_poke && done) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("start_in_done_ignored", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    endtask

    initial begin
        logic [11:0] addrs [0:7];
        logic [15:0] ids   [0:7];
        logic        used  [0:1023];
        int          n, mode, bad;
        logic [15:0] tgt;

        rst = 1'b1; start = 1'b0; target_id = '0; rd_valid = 1'b0; rd_data = '0;
        fill_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_cap_offset", 32'(cap_offset), 32'd0);
        check("rst_hops", 32'(hops), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-entry chain, zero wait, hit on second entry.
        fill_mem();
        mem[12'h100 >> 2] = hdr(16'h0001, 4'h1, 12'h148);
        mem[12'h148 >> 2] = hdr(16'h0019, 4'h1, 12'h000);
        walk(16'h0019, 0, 1'b0, 1'b1);
        check("chain_hit_offset", 32'(cap_offset), 32'h148);
        check("chain_hit_hops", 32'(hops), 32'd2);

        // Same chain, miss, 3 wait states, start poked while busy.
        walk(16'h000B, 3, 1'b1, 1'b0);
        check("chain_miss_found", 32'(found), 32'd0);

        // Empty list and all-ones header.
        mem[12'h100 >> 2] = 32'h0;
        walk(16'h0019, 0, 1'b0, 1'b0);
        mem[12'h100 >> 2] = 32'hFFFF_FFFF;
        walk(16'h0019, 1, 1'b0, 1'b0);
        check("all_ones_error", 32'(error), 32'd2);

        // Bad pointers: below 100h and misaligned.
        mem[12'h100 >> 2] = hdr(16'h0001, 4'h1, 12'h0FC);
        walk(16'h0019, 0, 1'b0, 1'b0);
        mem[12'h100 >> 2] = hdr(16'h0001, 4'h1, 12'h14A);
        walk(16'h0019, 2, 1'b0, 1'b0);

        // Self loop hits the hop limit.
        mem[12'h100 >> 2] = hdr(16'h0001, 4'h1, 12'h100);
        walk(16'h0019, 0, 1'b0, 1'b0);
        check("loop_error", 32'(error), 32'd3);
        check("loop_hops", 32'(hops), 32'd64);

        // Read timeout.
        walk(16'h0019, -1, 1'b0, 1'b0);
        check("timeout_error", 32'(error), 32'd1);

        // Reset in the middle of a request: no result, outputs cleared.
        wmode = -1;
        pulse_start(16'h0019);
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_rd_req", 32'(rd_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_rd_req", 32'(rd_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_rst_hops", 32'(hops), 32'd0);
        rst = 1'b0;
        // Stray responses in IDLE must be ignored.
        spur = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        spur = 1'b0;
        check("spur_idle_busy", 32'(busy), 32'd0);
        check("spur_idle_hops", 32'(hops), 32'd0);
        repeat (20) @(posedge clk);
        #1;

        // Randomised lists.
        for (int it = 0; it < 40; it++) begin
            fill_mem();
            for (int i = 0; i < 1024; i++) used[i] = 1'b0;
            n = $urandom_range(1, 6);
            addrs[0] = 12'h100;
            used[12'h100 >> 2] = 1'b1;
            for (int k = 1; k < n; k++) begin
                do addrs[k] = 12'h100 + 12'(4 * $urandom_range(1, 959));
                while (used[addrs[k][11:2]]);
                used[addrs[k][11:2]] = 1'b1;
            end
            for (int k = 0; k < n; k++) ids[k] = 16'($urandom_range(1, 8));
            mode = $urandom_range(0, 9);
            for (int k = 0; k < n; k++)
                mem[addrs[k][11:2]] = hdr(ids[k], 4'($urandom), (k == n - 1) ? 12'h0 : addrs[k + 1]);
            if (mode == 0) begin
                bad = $urandom_range(0, 1);
                mem[addrs[n-1][11:2]][31:20] = bad ? 12'(4 * $urandom_range(1, 63))
                                                   : 12'h100 + 12'($urandom_range(0, 3839) | 1);
            end else if (mode == 1) begin
                mem[addrs[n-1][11:2]][31:20] = 12'h100;
            end else if (mode == 2) begin
                mem[addrs[$urandom_range(0, n - 1)][11:2]] = 32'hFFFF_FFFF;
            end
            tgt = $urandom_range(0, 1) ? ids[$urandom_range(0, n - 1)] : 16'($urandom_range(1, 10));
            walk(tgt, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        check("addr_queue_drained", 32'(addrq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
